ex_muldiv: RTL and testbench
============================

Name: ex_muldiv

Overview:
- Multi-cycle RV32M multiply/divide unit that sits beside the single-cycle EX ALU in the 5-stage pipeline.
- Parametrised in data width and multiplier radix.
- Accepts one M-extension operation at a time. Raises a stall request to the pipeline controller until the result is ready, then presents the result with its destination register for the EX/MEM latch.
- Supports cancellation by a pipeline flush (branch/jump redirect).

Parameters:
XLEN, 32, operand/result width; must be even and ≥ 8
MUL_BITS, 4, multiplier bits retired per cycle; must divide XLEN; K = XLEN/MUL_BITS iterations

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-low
start_i  in  1  request: launch op_i on rs1_i/rs2_i
op_i  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
rs1_i  in  XLEN  operand A (dividend / multiplicand)
rs2_i  in  XLEN  operand B (divisor / multiplier)
wd_i  in  5  destination register address
flush_i  in  1  cancel in-flight op
busy_o  out  1  unit not IDLE
stall_req_o  out  1  hold upstream stages
done_o  out  1  one-cycle result-valid pulse
result_o  out  XLEN  result; held until next accepted start
wd_o  out  5  destination captured at start
wreg_o  out  1  write-enable; equals done_o

Behaviour:
- Reset (rst==0 at an edge):
  - state=IDLE.
  - All outputs 0; iteration counter, accumulators and operand registers 0.
  - Reset has priority over flush_i and start_i.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE:
  - start_i=1 latches operands, op and wd_i.
  - Next state: DIV for op 4-7; MUL for op 0-3.
  - Next state is DONE directly when:
    - Division by zero: DIV/DIVU quotient = all ones; REM/REMU result = rs1.
    - Signed overflow: DIV/REM with rs1 = 100..0 and rs2 = all ones; DIV result = rs1, REM result = 0.
- MUL:
  - Shift-add on operand magnitudes, MUL_BITS bits per cycle, into a 2*XLEN accumulator.
  - After K cycles go to FIX.
  - Sign handling: MULH signed×signed; MULHSU signed rs1 × unsigned rs2; MULHU and MUL on unsigned magnitudes.
- DIV:
  - Restoring divider on magnitudes, 1 quotient bit per cycle.
  - After XLEN cycles go to FIX.
- FIX:
  - Apply sign correction:
    - MUL family: negate the product if the signs differ.
    - DIV: negate the quotient if the operand signs differ.
    - REM: remainder takes the sign of the dividend.
  - Select the result: MUL gives product[XLEN-1:0]; MULH/MULHSU/MULHU give product[2XLEN-1:XLEN].
  - Load result_o. Go to DONE.
- DONE:
  - done_o=1 and wreg_o=1 for exactly one cycle, then go to IDLE.
  - A start_i arriving in DONE is ignored. The controller re-presents it, since the stall is released in DONE.
- Latency, counting from the edge that samples start_i to the cycle in which done_o=1:
  - Multiply: K+2 cycles (10 with defaults).
  - Divide: XLEN+2 cycles (34).
  - Special cases: 1 cycle.
- stall_req_o:
  - Combinational (start_i & IDLE), OR state in {MUL, DIV, FIX}.
  - Low in DONE, so the pipeline advances with the result.
- busy_o = state ≠ IDLE.
- start_i while busy: ignored; latched operands are unchanged.
- flush_i=1 at an edge, any state other than IDLE:
  - Next state IDLE; no done_o pulse.
  - result_o and wd_o keep their previous values.
  - flush_i with start_i in IDLE: the start is dropped.
- All internal arithmetic uses explicit widths. No reliance on Verilog sign-context inference beyond $signed on the declared operands.

Decomposition:
- Shared defines.v gains:
  - MulDivOpBus (2:0).
  - Op encodings OpMUL..OpREMU.
  - State encoding MdIDLE..MdDONE (3 bits).
  - OptcodeCalc funct7 value 7'b0000001 for decode.
- One natural sub-module: ex_div_core.
  - Restoring-divider datapath: remainder/quotient registers and the 1-bit step.
  - Interface: load, step and operand inputs; quotient and remainder outputs.
- The multiplier stays inline in ex_muldiv.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD (-3) -> result_o=0xFFFFFFEB, done_o pulses 10 cycles after start, wreg_o=1, wd_o=captured wd_i, stall_req_o low only in DONE.
- MULH 0x80000000×0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7%2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100%7 -> 2; each done_o 34 cycles after start.
- DIVU 5/0 -> 0xFFFFFFFF; REMU 5%0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0; each done_o 1 cycle after start.
- DIV started, flush_i at iteration 10 -> busy_o=0 next cycle, no done_o pulse, result_o unchanged; immediate new MUL 3×4 -> result 12 after 10 cycles.
- rst=0 mid-DIV -> all outputs 0 and state IDLE at that edge. Separately, a start_i presented while MUL is busy is ignored and the first result is unaffected.

Source files
------------

// File: rtl/ex_muldiv_pkg.sv
// Shared types for the RV32M multiply/divide unit: funct3 op codes, FSM states and
// the funct7 value that selects the M extension in decode.
package ex_muldiv_pkg;

  typedef enum logic [2:0] {
    OpMul    = 3'd0,
    OpMulh   = 3'd1,
    OpMulhsu = 3'd2,
    OpMulhu  = 3'd3,
    OpDiv    = 3'd4,
    OpDivu   = 3'd5,
    OpRem    = 3'd6,
    OpRemu   = 3'd7
  } md_op_e;

  typedef enum logic [2:0] {
    MdIdle = 3'd0,
    MdMul  = 3'd1,
    MdDiv  = 3'd2,
    MdFix  = 3'd3,
    MdDone = 3'd4
  } md_state_e;

  localparam logic [6:0] OptcodeCalc = 7'b0000001;

  function automatic logic is_div_op(input md_op_e op);
    return op[2];
  endfunction

endpackage

// File: rtl/ex_div_core.sv
// Restoring divider datapath on unsigned magnitudes; one quotient bit per step.
module ex_div_core #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            step_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o
);

  logic [XLEN-1:0] rem_q, quo_q, dvsr_q;
  logic [XLEN:0]   shifted, diff;

  // quo_q doubles as the dividend shift register: its MSB feeds the partial remainder.
  assign shifted = {rem_q, quo_q[XLEN-1]};
  assign diff    = shifted - {1'b0, dvsr_q};

  always_ff @(posedge clk) begin
    if (!rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvsr_q <= '0;
    end else if (load_i) begin
      rem_q  <= '0;
      quo_q  <= dividend_i;
      dvsr_q <= divisor_i;
    end else if (step_i) begin
      if (!diff[XLEN]) begin
        rem_q <= diff[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], 1'b1};
      end else begin
        rem_q <= shifted[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], 1'b0};
      end
    end
  end

  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/ex_muldiv.sv
// Multi-cycle RV32M multiply/divide unit beside the EX ALU. Stalls the pipeline
// while an op is in flight and pulses done_o with the result for the EX/MEM latch.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MUL_BITS = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [4:0]      wd_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            stall_req_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      wd_o,
  output logic            wreg_o
);

  localparam int unsigned K    = XLEN / MUL_BITS;
  localparam int unsigned CntW = $clog2(XLEN + 1);
  localparam int unsigned SumW = XLEN + MUL_BITS;

  md_state_e state_q, state_d;
  md_op_e    op_q, op_in;
  logic [4:0]      wd_q;
  logic            neg_q;
  logic [CntW-1:0] cnt_q;
  logic [XLEN-1:0] mcand_q, mul_hi_q, mul_lo_q;

  logic            sign_a, sign_b, div_zero, div_ovf, special, accept;
  logic [XLEN-1:0] mag_a, mag_b, special_res, fix_res;
  logic [XLEN-1:0] quotient, remainder, quo_fix, rem_fix;
  logic [SumW-1:0] mul_sum;
  logic [2*XLEN-1:0] prod, prod_fix;

  assign op_in  = md_op_e'(op_i);
  assign sign_a = rs1_i[XLEN-1] & (op_in inside {OpMulh, OpMulhsu, OpDiv, OpRem});
  assign sign_b = rs2_i[XLEN-1] & (op_in inside {OpMulh, OpDiv, OpRem});
  assign mag_a  = sign_a ? ({XLEN{1'b0}} - rs1_i) : rs1_i;
  assign mag_b  = sign_b ? ({XLEN{1'b0}} - rs2_i) : rs2_i;

  // Divide-by-zero and MIN/-1 bypass the iterative datapath entirely.
  assign div_zero = (rs2_i == '0);
  assign div_ovf  = (op_in inside {OpDiv, OpRem}) && (rs1_i == {1'b1, {(XLEN-1){1'b0}}})
                    && (rs2_i == '1);
  assign special  = is_div_op(op_in) & (div_zero | div_ovf);
  assign accept   = (state_q == MdIdle) & start_i & ~flush_i;

  always_comb begin
    special_res = '0;
    if (div_zero) begin
      special_res = op_in[1] ? rs1_i : '1;
    end else if (div_ovf) begin
      special_res = op_in[1] ? '0 : rs1_i;
    end
  end

  // Retire MUL_BITS multiplier bits: add the partial product to the high half, shift right.
  assign mul_sum = {{MUL_BITS{1'b0}}, mul_hi_q}
                 + ({{MUL_BITS{1'b0}}, mcand_q}
                    * {{XLEN{1'b0}}, mul_lo_q[MUL_BITS-1:0]});

  assign prod     = {mul_hi_q, mul_lo_q};
  assign prod_fix = neg_q ? ({(2*XLEN){1'b0}} - prod) : prod;
  assign quo_fix  = neg_q ? ({XLEN{1'b0}} - quotient) : quotient;
  assign rem_fix  = neg_q ? ({XLEN{1'b0}} - remainder) : remainder;

  always_comb begin
    fix_res = '0;
    unique case (op_q)
      OpMul:                     fix_res = prod_fix[XLEN-1:0];
      OpMulh, OpMulhsu, OpMulhu: fix_res = prod_fix[2*XLEN-1:XLEN];
      OpDiv, OpDivu:             fix_res = quo_fix;
      OpRem, OpRemu:             fix_res = rem_fix;
      default:                   fix_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MdIdle: begin
        if (start_i && !flush_i) begin
          if (special)              state_d = MdDone;
          else if (is_div_op(op_in)) state_d = MdDiv;
          else                      state_d = MdMul;
        end
      end
      MdMul:   if (cnt_q == CntW'(K - 1))    state_d = MdFix;
      MdDiv:   if (cnt_q == CntW'(XLEN - 1)) state_d = MdFix;
      MdFix:   state_d = MdDone;
      MdDone:  state_d = MdIdle;
      default: state_d = MdIdle;
    endcase
    if (flush_i && state_q != MdIdle) state_d = MdIdle;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= MdIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      op_q     <= OpMul;
      wd_q     <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mul_hi_q <= '0;
      mul_lo_q <= '0;
      result_o <= '0;
      wd_o     <= '0;
    end else if (accept) begin
      op_q     <= op_in;
      wd_q     <= wd_i;
      neg_q    <= (op_in == OpRem) ? sign_a : (sign_a ^ sign_b);
      cnt_q    <= '0;
      mcand_q  <= mag_a;
      mul_hi_q <= '0;
      mul_lo_q <= mag_b;
      if (special) begin
        result_o <= special_res;
        wd_o     <= wd_i;
      end
    end else begin
      case (state_q)
        MdMul: begin
          cnt_q    <= cnt_q + CntW'(1);
          mul_hi_q <= mul_sum[SumW-1:MUL_BITS];
          mul_lo_q <= {mul_sum[MUL_BITS-1:0], mul_lo_q[XLEN-1:MUL_BITS]};
        end
        MdDiv: cnt_q <= cnt_q + CntW'(1);
        MdFix: begin
          if (!flush_i) begin
            result_o <= fix_res;
            wd_o     <= wd_q;
          end
        end
        default: ;
      endcase
    end
  end

  ex_div_core #(
    .XLEN(XLEN)
  ) u_div_core (
    .clk        (clk),
    .rst        (rst),
    .load_i     (accept & is_div_op(op_in)),
    .step_i     (state_q == MdDiv),
    .dividend_i (mag_a),
    .divisor_i  (mag_b),
    .quotient_o (quotient),
    .remainder_o(remainder)
  );

  assign busy_o      = (state_q != MdIdle);
  assign done_o      = (state_q == MdDone);
  assign wreg_o      = done_o;
  assign stall_req_o = (start_i && state_q == MdIdle) || (state_q inside {MdMul, MdDiv, MdFix});

endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: directed RV32M cases, flush/reset/busy scenarios and random ops
// checked against a 64-bit arithmetic reference model.
module tb_ex_muldiv;

  localparam int LatMul = 10;
  localparam int LatDiv = 34;

  logic        clk, rst, start_i, flush_i;
  logic [2:0]  op_i;
  logic [31:0] rs1_i, rs2_i;
  logic [4:0]  wd_i;
  logic        busy_o, stall_req_o, done_o, wreg_o;
  logic [31:0] result_o;
  logic [4:0]  wd_o;

  int vectors = 0;
  int miscompares = 0;

  ex_muldiv #(
    .XLEN(32),
    .MUL_BITS(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .op_i       (op_i),
    .rs1_i      (rs1_i),
    .rs2_i      (rs2_i),
    .wd_i       (wd_i),
    .flush_i    (flush_i),
    .busy_o     (busy_o),
    .stall_req_o(stall_req_o),
    .done_o     (done_o),
    .result_o   (result_o),
    .wd_o       (wd_o),
    .wreg_o     (wreg_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] sa, ua, sb, ub, p;
    int si, sj;
    logic [31:0] r;
    sa = {{32{a[31]}}, a};
    ua = {32'b0, a};
    sb = {{32{b[31]}}, b};
    ub = {32'b0, b};
    si = a;
    sj = b;
    r  = '0;
    case (op)
      3'd0: begin p = ua * ub; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else r = si / sj;
      end
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
        else r = si % sj;
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    if (op < 3'd4) return LatMul;
    if (b == 0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return LatDiv;
  endfunction

  // Launches one op from IDLE and waits (bounded) for done_o; lands back in IDLE.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] wd, output int lat, output logic [31:0] res,
                       output logic [4:0] wdo, output logic wr, output logic stall_ok);
    stall_ok = 1'b1;
    op_i = op; rs1_i = a; rs2_i = b; wd_i = wd; start_i = 1'b1;
    #1;
    if (!stall_req_o) stall_ok = 1'b0;
    @(posedge clk); #1;
    start_i = 1'b0;
    lat = 1;
    while (!done_o && lat < 200) begin
      if (!stall_req_o) stall_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (!done_o) lat = -1;
    res = result_o; wdo = wd_o; wr = wreg_o;
    if (stall_req_o) stall_ok = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; start_i = 1'b0; flush_i = 1'b0;
    op_i = '0; rs1_i = '0; rs2_i = '0; wd_i = '0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({busy_o, stall_req_o, done_o, wreg_o, result_o, wd_o} !== 41'h0) begin
      miscompares++;
      $display("FAIL reset_outputs got %h want 0",
               {busy_o, stall_req_o, done_o, wreg_o, result_o, wd_o});
    end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed(input string name, input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] want,
                               input int want_lat, input logic [4:0] wd);
    int lat; logic [31:0] res; logic [4:0] wdo; logic wr, st;
    issue(op, a, b, wd, lat, res, wdo, wr, st);
    vectors++;
    if (res !== want) begin
      miscompares++; $display("FAIL %s_result got %h want %h", name, res, want);
    end
    vectors++;
    if (lat != want_lat) begin
      miscompares++; $display("FAIL %s_latency got %0d want %0d", name, lat, want_lat);
    end
    vectors++;
    if (wdo !== wd || wr !== 1'b1) begin
      miscompares++; $display("FAIL %s_wd_wreg got %h/%b want %h/1", name, wdo, wr, wd);
    end
    vectors++;
    if (st !== 1'b1) begin
      miscompares++; $display("FAIL %s_stall got %b want 1 (high until DONE only)", name, st);
    end
  endtask

  task automatic test_mul();
    test_directed("mul_7xm3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, LatMul, 5'd11);
    test_directed("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, LatMul, 5'd1);
    test_directed("mulhu_ff", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LatMul, 5'd2);
    test_directed("mulhsu_ff", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LatMul,
                  5'd3);
  endtask

  task automatic test_div();
    test_directed("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, LatDiv, 5'd4);
    test_directed("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, LatDiv, 5'd5);
    test_directed("divu_100_7", 3'd5, 32'd100, 32'd7, 32'd14, LatDiv, 5'd6);
    test_directed("remu_100_7", 3'd7, 32'd100, 32'd7, 32'd2, LatDiv, 5'd7);
  endtask

  task automatic test_special();
    test_directed("divu_by0", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 5'd8);
    test_directed("remu_by0", 3'd7, 32'd5, 32'd0, 32'd5, 1, 5'd9);
    test_directed("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 5'd10);
    test_directed("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, 5'd12);
  endtask

  task automatic test_busy_start();
    int lat;
    logic [31:0] want;
    want = model(3'd0, 32'h0001_2345, 32'h0000_0567);
    op_i = 3'd0; rs1_i = 32'h0001_2345; rs2_i = 32'h0000_0567; wd_i = 5'd13; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; lat = 1;
    repeat (3) begin @(posedge clk); #1; lat++; end
    op_i = 3'd4; rs1_i = 32'd99; rs2_i = 32'd0; wd_i = 5'd20; start_i = 1'b1;
    vectors++;
    if (stall_req_o !== 1'b1) begin
      miscompares++; $display("FAIL busy_start_stall got %b want 1", stall_req_o);
    end
    @(posedge clk); #1;
    start_i = 1'b0; lat++;
    while (!done_o && lat < 200) begin @(posedge clk); #1; lat++; end
    vectors++;
    if (lat != LatMul) begin
      miscompares++; $display("FAIL busy_start_latency got %0d want %0d", lat, LatMul);
    end
    vectors++;
    if (result_o !== want || wd_o !== 5'd13) begin
      miscompares++;
      $display("FAIL busy_start_result got %h/%h want %h/%h", result_o, wd_o, want, 5'd13);
    end
    @(posedge clk); #1;
    vectors++;
    if (busy_o !== 1'b0) begin
      miscompares++; $display("FAIL busy_start_ignored got busy=%b want 0", busy_o);
    end
  endtask

  task automatic test_flush();
    int lat; logic [31:0] res; logic [4:0] wdo; logic wr, st;
    issue(3'd0, 32'd5, 32'd6, 5'd9, lat, res, wdo, wr, st);
    op_i = 3'd5; rs1_i = 32'd1000; rs2_i = 32'd3; wd_i = 5'd17; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    vectors++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      miscompares++; $display("FAIL flush_idle got busy=%b done=%b want 0/0", busy_o, done_o);
    end
    vectors++;
    if (result_o !== 32'd30 || wd_o !== 5'd9) begin
      miscompares++;
      $display("FAIL flush_hold got %h/%h want %h/%h", result_o, wd_o, 32'd30, 5'd9);
    end
    test_directed("flush_then_mul", 3'd0, 32'd3, 32'd4, 32'd12, LatMul, 5'd21);
  endtask

  task automatic test_reset_mid();
    op_i = 3'd4; rs1_i = 32'd12345; rs2_i = 32'd7; wd_i = 5'd22; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({busy_o, stall_req_o, done_o, wreg_o, result_o, wd_o} !== 41'h0) begin
      miscompares++;
      $display("FAIL reset_mid_outputs got %h want 0",
               {busy_o, stall_req_o, done_o, wreg_o, result_o, wd_o});
    end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int lat; logic [31:0] res, a, b, want; logic [4:0] wdo, wd; logic wr, st;
    logic [2:0] op;
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      wd = 5'($urandom_range(0, 31));
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = a & 32'hFF; b = b & 32'hF; end
        3: b = b & 32'hFFF;
        default: ;
      endcase
      want = model(op, a, b);
      issue(op, a, b, wd, lat, res, wdo, wr, st);
      vectors++;
      if (res !== want || wdo !== wd) begin
        miscompares++;
        $display("FAIL rand_result op=%0d a=%h b=%h got %h/%h want %h/%h",
                 op, a, b, res, wdo, want, wd);
      end
      vectors++;
      if (lat != exp_lat(op, a, b)) begin
        miscompares++;
        $display("FAIL rand_latency op=%0d a=%h b=%h got %0d want %0d",
                 op, a, b, lat, exp_lat(op, a, b));
      end
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_busy_start();
    test_flush();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
